// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline.
// Holds the memory-stage FSM state type and alignment width.
package mips_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_t;

    // Low address bits that must be zero for a word access
    localparam int ALIGN_W = 2;

endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline register with bubble insertion.
// A bubble clears the controls and holds the data fields.
module mem_wb
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        bubble,
    input  logic        MemtoReg_In,
    input  logic        RegWrite_In,
    input  logic [4:0]  Rt_Rd_In,
    input  logic [31:0] ALUOUT_In,
    input  logic [31:0] ReadData_In,
    output logic        MemtoReg_Wb,
    output logic        RegWrite_Wb,
    output logic [4:0]  Rt_Rd_Wb,
    output logic [31:0] ALUOUT_Wb,
    output logic [31:0] ReadData_Wb
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            MemtoReg_Wb <= 1'b0;
            RegWrite_Wb <= 1'b0;
            Rt_Rd_Wb    <= 5'd0;
            ALUOUT_Wb   <= 32'd0;
            ReadData_Wb <= 32'd0;
        end else if (bubble) begin
            MemtoReg_Wb <= 1'b0;
            RegWrite_Wb <= 1'b0;
        end else begin
            MemtoReg_Wb <= MemtoReg_In;
            RegWrite_Wb <= RegWrite_In;
            Rt_Rd_Wb    <= Rt_Rd_In;
            ALUOUT_Wb   <= ALUOUT_In;
            ReadData_Wb <= ReadData_In;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack data bus with timeout,
// upstream stall generation and the MEM/WB register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemtoReg_Mem,
    input  logic        RegWrite_Mem,
    input  logic        MemWrite_Mem,
    input  logic        MemRead_Mem,
    input  logic [4:0]  Rt_Rd_Mem,
    input  logic [31:0] ALUOUT_Mem,
    input  logic [31:0] StoreVal_Mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic        bus_err,
    output logic        MemtoReg_Wb,
    output logic        RegWrite_Wb,
    output logic [4:0]  Rt_Rd_Wb,
    output logic [31:0] ALUOUT_Wb,
    output logic [31:0] ReadData_Wb
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    memState_t     state;
    logic [CW-1:0] wcnt;

    logic        memOp;
    logic        aligned;
    logic        misaligned;
    logic        done;
    logic        abandon;
    logic        wbRegWrite;
    logic [31:0] wbReadData;

    assign memOp      = MemRead_Mem | MemWrite_Mem;
    assign aligned    = (ALUOUT_Mem[ALIGN_W-1:0] == '0);
    assign misaligned = memOp & ~aligned;

    // Request is masked by reset so an in-flight access drops at once
    always_comb begin
        dmem_req  = 1'b0;
        done      = 1'b0;
        abandon   = 1'b0;
        stall_mem = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    dmem_req  = memOp & aligned;
                    done      = dmem_req & dmem_ack;
                    stall_mem = dmem_req & ~dmem_ack;
                end
                WAIT: begin
                    dmem_req  = 1'b1;
                    done      = dmem_ack;
                    abandon   = ~dmem_ack & (wcnt == TMAX);
                    stall_mem = ~dmem_ack & ~abandon;
                end
                default: ;
            endcase
        end
    end

    assign dmem_we    = dmem_req & MemWrite_Mem;
    assign dmem_addr  = ALUOUT_Mem;
    assign dmem_wdata = StoreVal_Mem;

    assign wbRegWrite = RegWrite_Mem & ~misaligned & ~abandon;
    assign wbReadData = (done & ~MemWrite_Mem) ? dmem_rdata : 32'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            wcnt    <= '0;
            bus_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (misaligned)
                        bus_err <= 1'b1;
                    if (stall_mem) begin
                        state <= WAIT;
                        wcnt  <= CW'(1);
                    end
                end
                WAIT: begin
                    if (done || abandon) begin
                        state <= IDLE;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + CW'(1);
                    end
                    if (abandon)
                        bus_err <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    mem_wb u_mem_wb (
        .clock       (clock),
        .reset       (reset),
        .bubble      (stall_mem),
        .MemtoReg_In (MemtoReg_Mem),
        .RegWrite_In (wbRegWrite),
        .Rt_Rd_In    (Rt_Rd_Mem),
        .ALUOUT_In   (ALUOUT_Mem),
        .ReadData_In (wbReadData),
        .MemtoReg_Wb (MemtoReg_Wb),
        .RegWrite_Wb (RegWrite_Wb),
        .Rt_Rd_Wb    (Rt_Rd_Wb),
        .ALUOUT_Wb   (ALUOUT_Wb),
        .ReadData_Wb (ReadData_Wb)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT = 4.
// Inputs change 1ns after posedge; outputs sampled at negedge or posedge+1.
module tb_mem_stage;

    logic        clock;
    logic        reset;
    logic        MemtoReg_Mem;
    logic        RegWrite_Mem;
    logic        MemWrite_Mem;
    logic        MemRead_Mem;
    logic [4:0]  Rt_Rd_Mem;
    logic [31:0] ALUOUT_Mem;
    logic [31:0] StoreVal_Mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_mem;
    logic        bus_err;
    logic        MemtoReg_Wb;
    logic        RegWrite_Wb;
    logic [4:0]  Rt_Rd_Wb;
    logic [31:0] ALUOUT_Wb;
    logic [31:0] ReadData_Wb;

    int checks = 0;
    int errors = 0;
    int stallCnt;

    mem_stage #(.TIMEOUT(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .MemtoReg_Mem (MemtoReg_Mem),
        .RegWrite_Mem (RegWrite_Mem),
        .MemWrite_Mem (MemWrite_Mem),
        .MemRead_Mem  (MemRead_Mem),
        .Rt_Rd_Mem    (Rt_Rd_Mem),
        .ALUOUT_Mem   (ALUOUT_Mem),
        .StoreVal_Mem (StoreVal_Mem),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .stall_mem    (stall_mem),
        .bus_err      (bus_err),
        .MemtoReg_Wb  (MemtoReg_Wb),
        .RegWrite_Wb  (RegWrite_Wb),
        .Rt_Rd_Wb     (Rt_Rd_Wb),
        .ALUOUT_Wb    (ALUOUT_Wb),
        .ReadData_Wb  (ReadData_Wb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idleIn();
        MemtoReg_Mem = 0; RegWrite_Mem = 0;
        MemWrite_Mem = 0; MemRead_Mem  = 0;
        Rt_Rd_Mem = 0; ALUOUT_Mem = 0; StoreVal_Mem = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chkWbZero(input string tag);
        chk({tag, ".MemtoReg"}, 32'(MemtoReg_Wb), 0);
        chk({tag, ".RegWrite"}, 32'(RegWrite_Wb), 0);
        chk({tag, ".Rt_Rd"}, 32'(Rt_Rd_Wb), 0);
        chk({tag, ".ALUOUT"}, ALUOUT_Wb, 0);
        chk({tag, ".ReadData"}, ReadData_Wb, 0);
    endtask

    initial begin
        idleIn();
        reset = 1;
        #12;
        chkWbZero("rst");
        chk("rst.req", 32'(dmem_req), 0);
        chk("rst.stall", 32'(stall_mem), 0);
        chk("rst.buserr", 32'(bus_err), 0);
        reset = 0;
        step();

        // ALU pass-through
        RegWrite_Mem = 1; Rt_Rd_Mem = 5; ALUOUT_Mem = 32'h10;
        @(negedge clock);
        chk("alu.stall", 32'(stall_mem), 0);
        chk("alu.req", 32'(dmem_req), 0);
        step();
        chk("alu.RegWrite", 32'(RegWrite_Wb), 1);
        chk("alu.Rt_Rd", 32'(Rt_Rd_Wb), 5);
        chk("alu.ALUOUT", ALUOUT_Wb, 32'h10);
        chk("alu.ReadData", ReadData_Wb, 0);

        // zero-wait load
        idleIn();
        MemRead_Mem = 1; MemtoReg_Mem = 1; RegWrite_Mem = 1;
        Rt_Rd_Mem = 9; ALUOUT_Mem = 32'h100;
        dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
        @(negedge clock);
        chk("ld0.req", 32'(dmem_req), 1);
        chk("ld0.we", 32'(dmem_we), 0);
        chk("ld0.stall", 32'(stall_mem), 0);
        step();
        chk("ld0.ReadData", ReadData_Wb, 32'hCAFEF00D);
        chk("ld0.RegWrite", 32'(RegWrite_Wb), 1);
        chk("ld0.MemtoReg", 32'(MemtoReg_Wb), 1);
        chk("ld0.Rt_Rd", 32'(Rt_Rd_Wb), 9);

        // 3-wait store
        idleIn();
        MemWrite_Mem = 1; ALUOUT_Mem = 32'h200; StoreVal_Mem = 32'h1234;
        stallCnt = 0;
        for (int c = 0; c < 4; c++) begin
            dmem_ack = (c == 3);
            @(negedge clock);
            if (stall_mem) stallCnt++;
            chk("st.req", 32'(dmem_req), 1);
            chk("st.we", 32'(dmem_we), 1);
            chk("st.addr", dmem_addr, 32'h200);
            chk("st.wdata", dmem_wdata, 32'h1234);
            chk("st.stall", 32'(stall_mem), (c < 3) ? 1 : 0);
            step();
            chk("st.RegWrite", 32'(RegWrite_Wb), 0);
            chk("st.MemtoReg", 32'(MemtoReg_Wb), 0);
        end
        chk("st.stallCnt", 32'(stallCnt), 3);
        chk("st.ALUOUT", ALUOUT_Wb, 32'h200);

        // timeout: 4 stall cycles then abandon
        idleIn();
        MemRead_Mem = 1; RegWrite_Mem = 1; MemtoReg_Mem = 1;
        Rt_Rd_Mem = 3; ALUOUT_Mem = 32'h300; dmem_rdata = 32'hDEAD;
        stallCnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (stall_mem) stallCnt++;
            chk("to.req", 32'(dmem_req), 1);
            chk("to.stall", 32'(stall_mem), (c < 4) ? 1 : 0);
            chk("to.buserr", 32'(bus_err), 0);
            step();
        end
        chk("to.stallCnt", 32'(stallCnt), 4);
        chk("to.buserr", 32'(bus_err), 1);
        chk("to.RegWrite", 32'(RegWrite_Wb), 0);
        chk("to.ReadData", ReadData_Wb, 0);
        chk("to.Rt_Rd", 32'(Rt_Rd_Wb), 3);

        // next load after timeout proceeds normally
        ALUOUT_Mem = 32'h304; Rt_Rd_Mem = 4;
        dmem_ack = 1; dmem_rdata = 32'h55AA;
        @(negedge clock);
        chk("ld1.stall", 32'(stall_mem), 0);
        step();
        chk("ld1.ReadData", ReadData_Wb, 32'h55AA);
        chk("ld1.RegWrite", 32'(RegWrite_Wb), 1);
        chk("ld1.buserr", 32'(bus_err), 1);

        // clear bus_err, then misaligned load (ack high but ignored)
        idleIn();
        reset = 1;
        #2;
        reset = 0;
        MemRead_Mem = 1; RegWrite_Mem = 1; Rt_Rd_Mem = 7;
        ALUOUT_Mem = 32'h102; dmem_ack = 1; dmem_rdata = 32'h77;
        @(negedge clock);
        chk("mis.req", 32'(dmem_req), 0);
        chk("mis.stall", 32'(stall_mem), 0);
        chk("mis.buserr0", 32'(bus_err), 0);
        step();
        chk("mis.buserr", 32'(bus_err), 1);
        chk("mis.RegWrite", 32'(RegWrite_Wb), 0);
        chk("mis.ReadData", ReadData_Wb, 0);
        chk("mis.Rt_Rd", 32'(Rt_Rd_Wb), 7);

        // reset during the 2nd WAIT cycle
        idleIn();
        MemRead_Mem = 1; RegWrite_Mem = 1;
        Rt_Rd_Mem = 7; ALUOUT_Mem = 32'h400;
        step();
        step();
        @(negedge clock);
        chk("rw.stall", 32'(stall_mem), 1);
        chk("rw.req", 32'(dmem_req), 1);
        reset = 1;
        #1;
        chk("rw.req0", 32'(dmem_req), 0);
        chk("rw.stall0", 32'(stall_mem), 0);
        chk("rw.buserr0", 32'(bus_err), 0);
        chkWbZero("rw");
        idleIn();
        #3;
        reset = 0;
        step();
        step();
        chk("rw.reqIdle", 32'(dmem_req), 0);
        chk("rw.stallIdle", 32'(stall_mem), 0);
        chk("rw.buserrIdle", 32'(bus_err), 0);
        chkWbZero("rwIdle");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
